// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RISC-V main control FSM
module main_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUOp,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // Moore vector: {AdrSrc, PCUpdate(JAL), Branch, MemWrite, RegWrite,
  //                ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal}
  localparam logic [13:0] MOORE_FETCH = 14'b0_0_0_0_0_00_10_10_00_0;

  state_t      cur_state;
  state_t      nxt_state;
  logic [13:0] moore_q;
  logic        fetch_go;
  logic        retire;

  function automatic state_t next_state(state_t s, logic [6:0] o, logic mr);
    state_t n;
    n = TRAP;
    case (s)
      FETCH:    n = mr ? DECODE : FETCH;
      DECODE: begin
        case (o)
          OP_LOAD, OP_STORE: n = MEMADR;
          OP_RTYPE:          n = EXECUTER;
          OP_ITYPE:          n = EXECUTEI;
          OP_BEQ:            n = BEQ;
          OP_JAL:            n = JAL;
          OP_LUI:            n = LUI;
          default:           n = TRAP;
        endcase
      end
      MEMADR:   n = (o == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = mr ? MEMWB : MEMREAD;
      MEMWB:    n = FETCH;
      MEMWRITE: n = mr ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL, LUI: n = ALUWB;
      ALUWB:    n = FETCH;
      BEQ:      n = FETCH;
      default:  n = TRAP;
    endcase
    return n;
  endfunction

  function automatic logic [13:0] moore_of(state_t s);
    logic [13:0] v;
    v = 14'b0_0_0_0_0_00_00_00_00_1;
    case (s)
      FETCH:    v = MOORE_FETCH;
      DECODE:   v = 14'b0_0_0_0_0_01_01_00_00_0;
      MEMADR:   v = 14'b0_0_0_0_0_10_01_00_00_0;
      MEMREAD:  v = 14'b1_0_0_0_0_00_00_00_00_0;
      MEMWB:    v = 14'b0_0_0_0_1_00_00_01_00_0;
      MEMWRITE: v = 14'b1_0_0_1_0_00_00_00_00_0;
      EXECUTER: v = 14'b0_0_0_0_0_10_00_00_10_0;
      EXECUTEI: v = 14'b0_0_0_0_0_10_01_00_10_0;
      ALUWB:    v = 14'b0_0_0_0_1_00_00_00_00_0;
      BEQ:      v = 14'b0_0_1_0_0_10_00_00_01_0;
      JAL:      v = 14'b0_1_0_0_0_01_10_00_00_0;
      LUI:      v = 14'b0_0_0_0_0_11_01_00_00_0;
      default:  v = 14'b0_0_0_0_0_00_00_00_00_1;
    endcase
    return v;
  endfunction

  always_comb begin
    nxt_state = next_state(cur_state, op, mem_ready);
  end

  assign retire = (cur_state == ALUWB) || (cur_state == MEMWB) || (cur_state == BEQ) ||
                  ((cur_state == MEMWRITE) && mem_ready);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
      moore_q   <= MOORE_FETCH;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      moore_q   <= moore_of(nxt_state);
      if (retire) begin
        instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // The fetch strobes are the only Mealy terms; reset gates them directly.
  assign fetch_go = reset && mem_ready && (cur_state == FETCH);

  assign AdrSrc    = moore_q[13];
  assign IRWrite   = fetch_go;
  assign PCUpdate  = moore_q[12] | fetch_go;
  assign Branch    = moore_q[11];
  assign MemWrite  = moore_q[10];
  assign RegWrite  = moore_q[9];
  assign ALUSrcA   = moore_q[8:7];
  assign ALUSrcB   = moore_q[6:5];
  assign ResultSrc = moore_q[4:3];
  assign ALUOp     = moore_q[2:1];
  assign illegal   = moore_q[0];
  assign state     = cur_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - self-checking bench for main_control_fsm
module tb_main_control_fsm;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;
  localparam logic [14:0] RST_OUTS = 15'b0_0_0_0_0_0_00_10_10_00_0;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;

  logic        AdrSrc, IRWrite, PCUpdate, Branch, MemWrite, RegWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        AdrSrc4, IRWrite4, PCUpdate4, Branch4, MemWrite4, RegWrite4, illegal4;
  logic [1:0]  ALUSrcA4, ALUSrcB4, ResultSrc4, ALUOp4;
  logic [3:0]  state4;
  logic [3:0]  instret4;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt    = 0;

  typedef struct {
    logic [6:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[$];

  main_control_fsm #(.INSTRET_W(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .instret(instret)
  );

  main_control_fsm #(.INSTRET_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .AdrSrc(AdrSrc4), .IRWrite(IRWrite4), .PCUpdate(PCUpdate4), .Branch(Branch4),
    .MemWrite(MemWrite4), .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4),
    .ResultSrc(ResultSrc4), .ALUOp(ALUOp4), .state(state4), .illegal(illegal4),
    .instret(instret4)
  );

  always #5 clk = ~clk;

  wire [14:0] outs  = {AdrSrc, IRWrite, PCUpdate, Branch, MemWrite, RegWrite,
                       ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal};
  wire [14:0] outs4 = {AdrSrc4, IRWrite4, PCUpdate4, Branch4, MemWrite4, RegWrite4,
                       ALUSrcA4, ALUSrcB4, ResultSrc4, ALUOp4, illegal4};

  // Output table per state: {AdrSrc,IRWrite,PCUpdate,Branch,MemWrite,RegWrite,A,B,Res,ALUOp,illegal}
  function automatic logic [14:0] exp_outs(logic [3:0] s, logic mr);
    case (s)
      4'd0:    return 15'b0_0_0_0_0_0_00_10_10_00_0 | {1'b0, mr, mr, 12'b0};
      4'd1:    return 15'b0_0_0_0_0_0_01_01_00_00_0;
      4'd2:    return 15'b0_0_0_0_0_0_10_01_00_00_0;
      4'd3:    return 15'b1_0_0_0_0_0_00_00_00_00_0;
      4'd4:    return 15'b0_0_0_0_0_1_00_00_01_00_0;
      4'd5:    return 15'b1_0_0_0_1_0_00_00_00_00_0;
      4'd6:    return 15'b0_0_0_0_0_0_10_00_00_10_0;
      4'd7:    return 15'b0_0_0_0_0_1_00_00_00_00_0;
      4'd8:    return 15'b0_0_0_0_0_0_10_01_00_10_0;
      4'd9:    return 15'b0_0_1_0_0_0_01_10_00_00_0;
      4'd10:   return 15'b0_0_0_1_0_0_10_00_00_01_0;
      4'd11:   return 15'b0_0_0_0_0_0_11_01_00_00_0;
      default: return 15'b0_0_0_0_0_0_00_00_00_00_1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, check mid-cycle, advance; the retirement count follows the state left.
  task automatic step(input logic [6:0] o, input logic mr, input logic [3:0] es);
    op = o;
    mem_ready = mr;
    @(negedge clk);
    chk("state", 32'(state), 32'(es));
    chk("state4", 32'(state4), 32'(es));
    chk("outs", 32'(outs), 32'(exp_outs(es, mr)));
    chk("outs4", 32'(outs4), 32'(exp_outs(es, mr)));
    chk("instret", instret, cnt);
    chk("instret4", 32'(instret4), 32'(cnt[3:0]));
    @(posedge clk);
    #1;
    if (es == 4'd4 || es == 4'd7 || es == 4'd10 || (es == 4'd5 && mr)) cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    op = OP_RTYPE;
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(outs), 32'(RST_OUTS));
    chk("rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cnt = 0;
  endtask

  // Higher-level model: each opcode class is a fixed list of steps; stall steps repeat while not ready.
  task automatic run_instr(input logic [6:0] iop);
    logic [3:0] plan[$];
    logic       mr;
    int         stalls;
    plan = '{4'd0, 4'd1};
    case (iop)
      OP_LOAD:  plan = {plan, 4'd2, 4'd3, 4'd4};
      OP_STORE: plan = {plan, 4'd2, 4'd5};
      OP_RTYPE: plan = {plan, 4'd6, 4'd7};
      OP_ITYPE: plan = {plan, 4'd8, 4'd7};
      OP_BEQ:   plan = {plan, 4'd10};
      OP_JAL:   plan = {plan, 4'd9, 4'd7};
      OP_LUI:   plan = {plan, 4'd11, 4'd7};
      default:  plan = {plan, 4'd15};
    endcase
    foreach (plan[i]) begin
      stalls = 0;
      do begin
        if (plan[i] == 4'd0 || plan[i] == 4'd3 || plan[i] == 4'd5)
          mr = (stalls < 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
        else
          mr = 1'($urandom_range(0, 1));
        step((plan[i] == 4'd1 || plan[i] == 4'd2) ? iop : 7'($urandom), mr, plan[i]);
        stalls++;
      end while ((plan[i] == 4'd0 || plan[i] == 4'd3 || plan[i] == 4'd5) && !mr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal[7];
    legal = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL, OP_LUI};

    vecs.push_back('{OP_RTYPE, 1'b1, 4'd0});
    vecs.push_back('{OP_RTYPE, 1'b1, 4'd1});
    vecs.push_back('{OP_RTYPE, 1'b1, 4'd6});
    vecs.push_back('{OP_RTYPE, 1'b1, 4'd7});
    vecs.push_back('{OP_LOAD,  1'b1, 4'd0});
    vecs.push_back('{OP_LOAD,  1'b1, 4'd1});
    vecs.push_back('{OP_LOAD,  1'b1, 4'd2});
    vecs.push_back('{OP_LOAD,  1'b0, 4'd3});
    vecs.push_back('{OP_LOAD,  1'b0, 4'd3});
    vecs.push_back('{OP_LOAD,  1'b0, 4'd3});
    vecs.push_back('{OP_LOAD,  1'b1, 4'd3});
    vecs.push_back('{OP_LOAD,  1'b1, 4'd4});
    vecs.push_back('{OP_STORE, 1'b0, 4'd0});
    vecs.push_back('{OP_STORE, 1'b0, 4'd0});
    vecs.push_back('{OP_STORE, 1'b1, 4'd0});
    vecs.push_back('{OP_STORE, 1'b1, 4'd1});
    vecs.push_back('{OP_STORE, 1'b1, 4'd2});
    vecs.push_back('{OP_STORE, 1'b0, 4'd5});
    vecs.push_back('{OP_STORE, 1'b0, 4'd5});
    vecs.push_back('{OP_STORE, 1'b1, 4'd5});
    vecs.push_back('{OP_BEQ,   1'b1, 4'd0});
    vecs.push_back('{OP_BEQ,   1'b1, 4'd1});
    vecs.push_back('{OP_BEQ,   1'b1, 4'd10});
    vecs.push_back('{OP_JAL,   1'b1, 4'd0});
    vecs.push_back('{OP_JAL,   1'b1, 4'd1});
    vecs.push_back('{OP_JAL,   1'b1, 4'd9});
    vecs.push_back('{OP_JAL,   1'b1, 4'd7});
    vecs.push_back('{OP_LUI,   1'b1, 4'd0});
    vecs.push_back('{OP_LUI,   1'b1, 4'd1});
    vecs.push_back('{OP_LUI,   1'b1, 4'd11});
    vecs.push_back('{OP_LUI,   1'b1, 4'd7});

    do_reset();
    foreach (vecs[i]) step(vecs[i].op, vecs[i].mr, vecs[i].st);
    chk("directed_retired", instret, 32'd6);

    for (int n = 0; n < 300; n++) run_instr(legal[$urandom_range(0, 6)]);

    do_reset();
    for (int n = 0; n < 15; n++) run_instr(OP_RTYPE);
    chk("wrap_pre", 32'(instret4), 32'd15);
    run_instr(OP_RTYPE);
    chk("wrap_post", 32'(instret4), 32'd0);
    chk("wrap_wide", instret, 32'd16);

    run_instr(OP_BAD);
    for (int n = 0; n < 20; n++) step(7'($urandom), 1'($urandom_range(0, 1)), 4'd15);

    do_reset();
    run_instr(OP_RTYPE);
    step(OP_STORE, 1'b1, 4'd0);
    step(OP_STORE, 1'b1, 4'd1);
    step(OP_STORE, 1'b1, 4'd2);
    step(OP_STORE, 1'b0, 4'd5);
    #2;
    chk("memwrite_stall", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_memwrite", 32'(MemWrite), 32'd0);
    chk("async_regwrite", 32'(RegWrite), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_instret", instret, 32'd0);
    chk("async_outs", 32'(outs), 32'(RST_OUTS));
    cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(OP_STORE);
    run_instr(OP_LOAD);
    chk("post_reset_retired", instret, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
